ddr_rst_seq: RTL and testbench

Reset sequencer that generates the staged reset releases for the DDR subsystem: PHY first, then controller, then user logic. It is the source end of the reset path; each output is re-synchronised in its destination domain by the existing two-flop reset synchroniser. It gates release on a stable PLL lock, waits for controller init with a timeout and bounded retry, and re-asserts all resets on lock loss or a software request.

---
 rtl/ddr_rst_seq.sv | 174 +++++++++++++++++
 tb/tb_ddr_rst_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rst_seq.sv
`timescale 1ns/1ps
// DDR reset sequencer: staged release of PHY, controller and user resets,
// gated on stable PLL lock, with init timeout, bounded retry and abort.
module ddr_rst_seq #(
    parameter int HOLD_CYCLES  = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int STAGE_GAP    = 8,
    parameter int INIT_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       init_done,
    input  logic       soft_rst_req,
    output logic       phy_rst_n,
    output logic       ctrl_rst_n,
    output logic       user_rst_n,
    output logic       seq_busy,
    output logic       init_err,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_GAP,
        S_WAIT_INIT,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_m;
    logic             lock_s;
    logic             init_m;
    logic             init_s;
    logic [3:0]       retry_nxt;

    assign retry_nxt = retry_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            init_m <= 1'b0;
            init_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
            init_m <= init_done;
            init_s <= init_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_HOLD;
            cnt        <= '0;
            phy_rst_n  <= 1'b0;
            ctrl_rst_n <= 1'b0;
            user_rst_n <= 1'b0;
            seq_busy   <= 1'b1;
            init_err   <= 1'b0;
            retry_cnt  <= 4'd0;
        end else if (soft_rst_req) begin
            state      <= S_HOLD;
            cnt        <= '0;
            phy_rst_n  <= 1'b0;
            ctrl_rst_n <= 1'b0;
            user_rst_n <= 1'b0;
            seq_busy   <= 1'b1;
            init_err   <= 1'b0;
            retry_cnt  <= 4'd0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // any low sample restarts the stability window
                S_WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state     <= S_GAP;
                        cnt       <= '0;
                        phy_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (!lock_s) begin
                        state      <= S_HOLD;
                        cnt        <= '0;
                        phy_rst_n  <= 1'b0;
                        ctrl_rst_n <= 1'b0;
                        user_rst_n <= 1'b0;
                        seq_busy   <= 1'b1;
                    end else if (cnt == GAP_LAST) begin
                        state      <= S_WAIT_INIT;
                        cnt        <= '0;
                        ctrl_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_INIT: begin
                    if (!lock_s) begin
                        state      <= S_HOLD;
                        cnt        <= '0;
                        phy_rst_n  <= 1'b0;
                        ctrl_rst_n <= 1'b0;
                        user_rst_n <= 1'b0;
                        seq_busy   <= 1'b1;
                    end else if (init_s) begin
                        state      <= S_RUN;
                        cnt        <= '0;
                        user_rst_n <= 1'b1;
                        seq_busy   <= 1'b0;
                        retry_cnt  <= 4'd0;
                    end else if (cnt == TO_LAST) begin
                        state      <= (retry_nxt == RETRY_MAX) ? S_FAIL
                                                               : S_HOLD;
                        cnt        <= '0;
                        phy_rst_n  <= 1'b0;
                        ctrl_rst_n <= 1'b0;
                        user_rst_n <= 1'b0;
                        seq_busy   <= (retry_nxt != RETRY_MAX);
                        init_err   <= 1'b1;
                        retry_cnt  <= retry_nxt;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state      <= S_HOLD;
                        cnt        <= '0;
                        phy_rst_n  <= 1'b0;
                        ctrl_rst_n <= 1'b0;
                        user_rst_n <= 1'b0;
                        seq_busy   <= 1'b1;
                    end
                end
                S_FAIL: begin
                    cnt <= '0;
                end
                default: begin
                    state      <= S_HOLD;
                    cnt        <= '0;
                    phy_rst_n  <= 1'b0;
                    ctrl_rst_n <= 1'b0;
                    user_rst_n <= 1'b0;
                    seq_busy   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rst_seq.sv
`timescale 1ns/1ps
// Bench for ddr_rst_seq: directed scenarios plus random lock/init/soft
// traffic, checked against a deadline-based reference model.
module tb_ddr_rst_seq;

    localparam int HOLD = 16;
    localparam int LOCK = 64;
    localparam int GAP  = 8;
    localparam int TO   = 32;
    localparam int MAXR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       init_done = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       phy_rst_n;
    logic       ctrl_rst_n;
    logic       user_rst_n;
    logic       seq_busy;
    logic       init_err;
    logic [3:0] retry_cnt;

    int tests = 0;
    int fails = 0;

    ddr_rst_seq #(
        .HOLD_CYCLES (HOLD),
        .LOCK_STABLE (LOCK),
        .STAGE_GAP   (GAP),
        .INIT_TIMEOUT(TO),
        .MAX_RETRY   (MAXR),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .init_done   (init_done),
        .soft_rst_req(soft_rst_req),
        .phy_rst_n   (phy_rst_n),
        .ctrl_rst_n  (ctrl_rst_n),
        .user_rst_n  (user_rst_n),
        .seq_busy    (seq_busy),
        .init_err    (init_err),
        .retry_cnt   (retry_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus absolute-edge deadlines.
    localparam int P_HOLD = 0, P_LOCK = 1, P_GAP = 2;
    localparam int P_INIT = 3, P_RUN = 4, P_FAIL = 5;

    int n;
    int phase;
    int mark;
    int last_low;
    int m_retry;
    bit m_err;
    bit lk_h1, lk_h2, in_h1, in_h2;

    task automatic model_reset();
        n = 0; phase = P_HOLD; mark = 0; last_low = 0;
        m_retry = 0; m_err = 0;
        lk_h1 = 0; lk_h2 = 0; in_h1 = 0; in_h2 = 0;
    endtask

    task automatic model_step();
        bit lk, ini;
        n   = n + 1;
        lk  = lk_h2;
        ini = in_h2;
        lk_h2 = lk_h1; lk_h1 = pll_lock;
        in_h2 = in_h1; in_h1 = init_done;
        if (soft_rst_req) begin
            phase = P_HOLD; mark = n; m_err = 0; m_retry = 0;
        end else if (phase == P_HOLD) begin
            if (n == mark + HOLD) begin
                phase = P_LOCK; mark = n; last_low = n;
            end
        end else if (phase == P_LOCK) begin
            if (!lk) last_low = n;
            else if (n - last_low == LOCK) begin
                phase = P_GAP; mark = n;
            end
        end else if (phase == P_FAIL) begin
            phase = P_FAIL;
        end else if (!lk) begin
            phase = P_HOLD; mark = n;
        end else if (phase == P_GAP) begin
            if (n == mark + GAP) begin
                phase = P_INIT; mark = n;
            end
        end else if (phase == P_INIT) begin
            if (ini) begin
                phase = P_RUN; m_retry = 0;
            end else if (n == mark + TO) begin
                m_err = 1;
                m_retry = m_retry + 1;
                phase = (m_retry == MAXR) ? P_FAIL : P_HOLD;
                mark = n;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s edge %0d: observed %0d expected %0d",
                   tag, n, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("phy", {3'b0, phy_rst_n},
            {3'b0, phase == P_GAP || phase == P_INIT || phase == P_RUN});
        chk("ctrl", {3'b0, ctrl_rst_n},
            {3'b0, phase == P_INIT || phase == P_RUN});
        chk("user", {3'b0, user_rst_n}, {3'b0, phase == P_RUN});
        chk("busy", {3'b0, seq_busy},
            {3'b0, !(phase == P_RUN || phase == P_FAIL)});
        chk("err", {3'b0, init_err}, {3'b0, m_err});
        chk("retry", retry_cnt, 4'(m_retry));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (n < target && guard < 20000) begin
            cycle();
            guard++;
        end
    endtask

    task automatic do_reset(input bit pl, input bit id);
        rst_n = 1'b0;
        soft_rst_req = 1'b0;
        pll_lock = pl;
        init_done = id;
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset(1'b1, 1'b1);
        chk("rst_phy", {3'b0, phy_rst_n}, 4'd0);
        chk("rst_busy", {3'b0, seq_busy}, 4'd1);
        chk("rst_retry", retry_cnt, 4'd0);
        run_to(79);
        chk("t1_phy79", {3'b0, phy_rst_n}, 4'd0);
        run_to(80);
        chk("t1_phy80", {3'b0, phy_rst_n}, 4'd1);
        chk("t1_ctrl80", {3'b0, ctrl_rst_n}, 4'd0);
        run_to(88);
        chk("t1_ctrl88", {3'b0, ctrl_rst_n}, 4'd1);
        chk("t1_user88", {3'b0, user_rst_n}, 4'd0);
        run_to(89);
        chk("t1_user89", {3'b0, user_rst_n}, 4'd1);
        chk("t1_busy89", {3'b0, seq_busy}, 4'd0);

        do_reset(1'b1, 1'b1);
        run_to(49);
        pll_lock = 1'b0;
        run_to(59);
        pll_lock = 1'b1;
        run_to(124);
        chk("t2_phy124", {3'b0, phy_rst_n}, 4'd0);
        run_to(125);
        chk("t2_phy125", {3'b0, phy_rst_n}, 4'd1);
        run_to(140);
        chk("t3_user140", {3'b0, user_rst_n}, 4'd1);
        pll_lock = 1'b0;
        run_to(142);
        chk("t3_user142", {3'b0, user_rst_n}, 4'd1);
        run_to(143);
        chk("t3_phy143", {3'b0, phy_rst_n}, 4'd0);
        chk("t3_user143", {3'b0, user_rst_n}, 4'd0);
        chk("t3_busy143", {3'b0, seq_busy}, 4'd1);
        pll_lock = 1'b1;
        run_to(222);
        chk("t3_phy222", {3'b0, phy_rst_n}, 4'd0);
        run_to(235);
        chk("t3_user235", {3'b0, user_rst_n}, 4'd1);
        chk("t3_retry", retry_cnt, 4'd0);

        do_reset(1'b1, 1'b0);
        run_to(119);
        chk("t4_err119", {3'b0, init_err}, 4'd0);
        run_to(120);
        chk("t4_err120", {3'b0, init_err}, 4'd1);
        chk("t4_retry1", retry_cnt, 4'd1);
        chk("t4_ctrl120", {3'b0, ctrl_rst_n}, 4'd0);
        run_to(240);
        chk("t4_retry2", retry_cnt, 4'd2);
        run_to(360);
        chk("t4_retry3", retry_cnt, 4'd3);
        chk("t4_busy_fail", {3'b0, seq_busy}, 4'd0);
        chk("t4_phy_fail", {3'b0, phy_rst_n}, 4'd0);
        pll_lock = 1'b0;
        run_to(380);
        pll_lock = 1'b1;
        chk("t4_retry_hold", retry_cnt, 4'd3);
        soft_rst_req = 1'b1;
        cycle();
        soft_rst_req = 1'b0;
        chk("t4_err_clr", {3'b0, init_err}, 4'd0);
        chk("t4_retry_clr", retry_cnt, 4'd0);
        chk("t4_busy_clr", {3'b0, seq_busy}, 4'd1);
        init_done = 1'b1;
        run_to(485);
        chk("t4_user_again", {3'b0, user_rst_n}, 4'd1);

        do_reset(1'b1, 1'b0);
        run_to(88);
        init_done = 1'b1;
        run_to(90);
        soft_rst_req = 1'b1;
        run_to(91);
        soft_rst_req = 1'b0;
        chk("t5_user91", {3'b0, user_rst_n}, 4'd0);
        chk("t5_ctrl91", {3'b0, ctrl_rst_n}, 4'd0);
        chk("t5_busy91", {3'b0, seq_busy}, 4'd1);
        run_to(96);
        chk("t5_user96", {3'b0, user_rst_n}, 4'd0);

        do_reset(1'b1, 1'b0);
        run_to(84);
        chk("t6_phy_gap", {3'b0, phy_rst_n}, 4'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        chk("t6_phy_async", {3'b0, phy_rst_n}, 4'd0);
        @(negedge clk);

        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) pll_lock = ~pll_lock;
            if ($urandom_range(0, 29) == 0) init_done = ~init_done;
            soft_rst_req = ($urandom_range(0, 249) == 0);
            cycle();
        end
        soft_rst_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
